// File: rtl/uart_memory_pkg.sv
// rtl/uart_memory_pkg.sv - Shared opcodes, packet lengths, FSM states and packet byte selection.
package uart_memory_pkg;

  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [3:0] READ_LEN  = 4'd5;
  localparam logic [3:0] WRITE_LEN = 4'd13;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TX_CMD   = 2'd1;
  localparam logic [1:0] ST_RX_DATA  = 2'd2;
  localparam logic [1:0] ST_WAIT_ACK = 2'd3;

  // Byte idx of the outgoing packet; every field goes out LSB byte first.
  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic wr,
                                          input logic [31:0] a, input logic [31:0] w,
                                          input logic [31:0] m);
    logic [7:0] b;
    case (idx)
      4'd0:    b = wr ? OP_WRITE : OP_READ;
      4'd1:    b = a[7:0];
      4'd2:    b = a[15:8];
      4'd3:    b = a[23:16];
      4'd4:    b = a[31:24];
      4'd5:    b = w[7:0];
      4'd6:    b = w[15:8];
      4'd7:    b = w[23:16];
      4'd8:    b = w[31:24];
      4'd9:    b = m[7:0];
      4'd10:   b = m[15:8];
      4'd11:   b = m[23:16];
      4'd12:   b = m[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_memory_if.sv
// rtl/uart_memory_if.sv - Command/response bus between a requester and uart_memory.
interface uart_memory_if;
  logic        cmd_start;
  logic        cmd_write;
  logic        cmd_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic        rdata_valid;

  modport master (output cmd_start, cmd_write, addr, wdata, wmask,
                  input  cmd_ready, rdata, rdata_valid);
  modport slave  (input  cmd_start, cmd_write, addr, wdata, wmask,
                  output cmd_ready, rdata, rdata_valid);
endinterface

// File: rtl/uart_memory_phy.sv
// rtl/uart_memory_phy.sv - Byte-level 8N1 UART transmitter and receiver.
module uart_memory_phy #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_BITS  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_sh_q, tx_sh_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_last;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]  rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_valid_q, rx_valid_d;

  // A new start accepted in the final stop-bit cycle keeps bytes gapless.
  assign tx_last = tx_busy_q && (tx_cnt_q == FULL) && (tx_bit_q == 4'd9);

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    if (tx_start && (!tx_busy_q || tx_last)) begin
      tx_busy_d = 1'b1;
      tx_sh_d   = {1'b1, tx_data, 1'b0};
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
    end else if (tx_last) begin
      tx_busy_d = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == FULL) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 4'd1;
        tx_sh_d  = {1'b1, tx_sh_q[9:1]};
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d  = RX_START;
        rx_cnt_d = '0;
      end
      RX_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? RX_IDLE : RX_BITS;
      end else begin
        rx_cnt_d = rx_cnt_q + 16'd1;
      end
      RX_BITS: if (rx_cnt_q == FULL) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        else                  rx_bit_d = rx_bit_q + 3'd1;
      end else begin
        rx_cnt_d = rx_cnt_q + 16'd1;
      end
      default: if (rx_cnt_q == FULL) begin
        rx_st_d    = RX_IDLE;
        rx_valid_d = rx_s2_q;
      end else begin
        rx_cnt_d = rx_cnt_q + 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_busy       = tx_busy_q;
  assign tx_done       = tx_last;
  assign uart_tx       = tx_busy_q ? tx_sh_q[0] : 1'b1;
  assign rx_byte       = rx_sh_q;
  assign rx_byte_valid = rx_valid_q;

endmodule

// File: rtl/uart_memory.sv
// rtl/uart_memory.sv - Memory read/write commands tunnelled to a host over UART.
// Define UART_MEMORY_WRITE_ACK_EN to hold writes until the host returns an ack byte.
module uart_memory
  import uart_memory_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst,
  uart_memory_if.slave  bus,
  input  logic          uart_rx,
  output logic          uart_tx
);

  logic [1:0]  state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wmask_q, wmask_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0] sh_q, sh_d, rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic        tx_start, tx_busy, tx_done, rx_byte_valid;
  logic [7:0]  tx_data, rx_byte;
  logic [3:0]  pkt_len;

  uart_memory_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk           (clk),
    .rst           (rst),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .uart_tx       (uart_tx),
    .uart_rx       (uart_rx),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid)
  );

  assign pkt_len = wr_q ? WRITE_LEN : READ_LEN;
  assign tx_data = pkt_byte(idx_q, wr_q, addr_q, wdata_q, wmask_q);

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    idx_d         = idx_q;
    rx_cnt_d      = rx_cnt_q;
    sh_d          = sh_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    tx_start      = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.cmd_start) begin
        wr_d          = bus.cmd_write;
        addr_d        = bus.addr;
        wdata_d       = bus.wdata;
        wmask_d       = bus.wmask;
        idx_d         = '0;
        rdata_valid_d = 1'b0;
        state_d       = ST_TX_CMD;
      end
      ST_TX_CMD: begin
        if ((idx_q != pkt_len) && (!tx_busy || tx_done)) begin
          tx_start = 1'b1;
          idx_d    = idx_q + 4'd1;
        end else if (tx_done) begin
          if (wr_q) begin
`ifdef UART_MEMORY_WRITE_ACK_EN
            state_d = ST_WAIT_ACK;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            rx_cnt_d = '0;
            state_d  = ST_RX_DATA;
          end
        end
      end
      ST_RX_DATA: if (rx_byte_valid) begin
        sh_d = {rx_byte, sh_q[31:8]};
        if (rx_cnt_q == 2'd3) begin
          rdata_d       = {rx_byte, sh_q[31:8]};
          rdata_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 2'd1;
        end
      end
`ifdef UART_MEMORY_WRITE_ACK_EN
      ST_WAIT_ACK: if (rx_byte_valid && (rx_byte == ACK_BYTE)) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      idx_q         <= '0;
      rx_cnt_q      <= '0;
      sh_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wmask_q       <= wmask_d;
      idx_q         <= idx_d;
      rx_cnt_q      <= rx_cnt_d;
      sh_q          <= sh_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_uart_memory.sv
// tb/tb_uart_memory.sv - Directed bench for uart_memory with a host-side UART model.
module tb_uart_memory;

  localparam int CPB   = 4;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;

  uart_memory_if bus ();

  uart_memory #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_b;
  int low_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Host-side decoder: samples uart_tx at mid-bit and queues every framed byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        repeat (CPB + CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          dec_b[i] = uart_tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx === 1'b1) tx_q.push_back(dec_b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] m);
    bus.cmd_start = 1'b1;
    bus.cmd_write = wr;
    bus.addr      = a;
    bus.wdata     = w;
    bus.wmask     = m;
    @(negedge clk);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!bus.cmd_ready && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (tx_q.size() < n && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("tx_count", 32'(tx_q.size()), 32'(n));
  endtask

  task automatic check_packet(input string tag);
    logic [7:0] got;
    wait_tx(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'h0, got}, {24'h0, exp_q[i]});
    end
    tx_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_start = 1'b0;
    bus.cmd_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.wmask     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_valid", 32'(bus.rdata_valid), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_tx", 32'(uart_tx), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic read
    issue(1'b0, 32'h0000_1234, 32'h0, 32'h0);
    check("rd1_ready_low", 32'(bus.cmd_ready), 32'd0);
    exp_q = '{8'h52, 8'h34, 8'h12, 8'h00, 8'h00};
    check_packet("rd1");
    repeat (4) @(negedge clk);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    wait_ready("rd1_done");
    check("rd1_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("rd1_valid", 32'(bus.rdata_valid), 32'd1);

    // New read accepted in the first ready cycle
    issue(1'b0, 32'hA5A5_0001, 32'h0, 32'h0);
    check("rd2_valid_clr", 32'(bus.rdata_valid), 32'd0);
    check("rd2_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("rd2_rdata_hold", bus.rdata, 32'hDEAD_BEEF);
    repeat (50) @(negedge clk);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q = '{8'h52, 8'h01, 8'h00, 8'hA5, 8'hA5};
    check_packet("rd2");
    repeat (4) @(negedge clk);
    send_byte(8'h11, 1'b0);
    repeat (CPB) @(negedge clk);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (10) @(negedge clk);
    check("rd2_3bytes_valid", 32'(bus.rdata_valid), 32'd0);
    check("rd2_3bytes_ready", 32'(bus.cmd_ready), 32'd0);
    check("rd2_3bytes_rdata", bus.rdata, 32'hDEAD_BEEF);
    send_byte(8'h12, 1'b1);
    wait_ready("rd2_done");
    check("rd2_rdata", bus.rdata, 32'h1234_5678);
    check("rd2_valid", 32'(bus.rdata_valid), 32'd1);

    // Write packet
    issue(1'b1, 32'h0000_0010, 32'hCAFE_BABE, 32'h0000_FFFF);
`ifdef UART_MEMORY_WRITE_ACK_EN
    exp_q = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hBA, 8'hFE, 8'hCA,
              8'hFF, 8'hFF, 8'h00, 8'h00};
    check_packet("wr1");
    repeat (10) @(negedge clk);
    check("wr1_wait_ack", 32'(bus.cmd_ready), 32'd0);
    send_byte(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    check("wr1_not_ack", 32'(bus.cmd_ready), 32'd0);
    send_byte(8'hA5, 1'b1);
    wait_ready("wr1_acked");
`else
    low_cycles = 0;
    while (!bus.cmd_ready && low_cycles < LIMIT) begin
      low_cycles++;
      @(negedge clk);
    end
    check("wr1_low_cycles", 32'(low_cycles), 32'(13 * 10 * CPB + 1));
    exp_q = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hBA, 8'hFE, 8'hCA,
              8'hFF, 8'hFF, 8'h00, 8'h00};
    check_packet("wr1");
`endif
    check("wr1_valid", 32'(bus.rdata_valid), 32'd0);
    check("wr1_rdata", bus.rdata, 32'h1234_5678);

    // Host byte while idle is ignored
    send_byte(8'h99, 1'b1);
    repeat (10) @(negedge clk);
    check("idle_rx_valid", 32'(bus.rdata_valid), 32'd0);
    check("idle_rx_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_rx_rdata", bus.rdata, 32'h1234_5678);

    // Reset in the middle of a write
    issue(1'b1, 32'h0000_0020, 32'h1122_3344, 32'hFFFF_FFFF);
    wait_tx(6);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(uart_tx), 32'd1);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rst_valid", 32'(bus.rdata_valid), 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("post_rst_tx_idle", 32'(uart_tx), 32'd1);
    tx_q.delete();

    // Read after reset
    issue(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    exp_q = '{8'h52, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_packet("rd3");
    repeat (4) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    wait_ready("rd3_done");
    check("rd3_rdata", bus.rdata, 32'h0403_0201);
    check("rd3_valid", 32'(bus.rdata_valid), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
